led_seq_checker: RTL and testbench

LED_SEQ_CHECKER -- requirements
Module: led_seq_checker

---
 rtl/led_seq_checker.sv | 142 ++++++++++++++
 tb/tb_led_seq_checker.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/led_seq_checker.sv
// led_seq_checker
//   Tracks an 8-step fill/drain LED pattern (00,03,0F,3F,FF,FC,F0,C0, then
//   back to 00). The checker hunts for 8'h00, locks, and then follows the
//   sequence. A pattern held for too long (stall) or an unexpected value
//   (mismatch) raises a one-clock error pulse and drops back to hunting.
//
// Parameters
//   MAX_HOLD  : max consecutive clocks a pattern may be held while locked (1..65535)
// Ports
//   clk       : system clock, rising edge
//   rs        : asynchronous active-high reset
//   led[7:0]  : LED bus sampled every clock
//   locked    : high while a valid sequence is being tracked
//   step[2:0] : index of the currently matched pattern, 0 when not locked
//   err       : one-clock pulse per detected sequence error
//   err_cnt   : saturating error count since reset
//   cycle_cnt : wrapping count of complete 8-step cycles since reset
module led_seq_checker #(
  parameter int unsigned MAX_HOLD = 1
) (
  input  logic       clk,
  input  logic       rs,
  input  logic [7:0] led,
  output logic       locked,
  output logic [2:0] step,
  output logic       err,
  output logic [7:0] err_cnt,
  output logic [7:0] cycle_cnt
);

  typedef enum logic {
    HUNT,
    LOCK
  } state_e;

  localparam logic [15:0] HOLD_LIMIT = 16'(MAX_HOLD);

  function automatic logic [7:0] pattern(input logic [2:0] idx);
    logic [7:0] p;
    case (idx)
      3'd0:    p = 8'h00;
      3'd1:    p = 8'h03;
      3'd2:    p = 8'h0F;
      3'd3:    p = 8'h3F;
      3'd4:    p = 8'hFF;
      3'd5:    p = 8'hFC;
      3'd6:    p = 8'hF0;
      default: p = 8'hC0;
    endcase
    return p;
  endfunction

  state_e      state_q, state_d;
  logic        locked_q, locked_d;
  logic [2:0]  step_q, step_d;
  logic [15:0] hold_q, hold_d;
  logic        err_q, err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [7:0]  cycle_cnt_q, cycle_cnt_d;
  logic        fault;

  always_comb begin
    state_d     = state_q;
    locked_d    = locked_q;
    step_d      = step_q;
    hold_d      = hold_q;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    fault       = 1'b0;

    case (state_q)
      HUNT: begin
        if (led == 8'h00) begin
          state_d  = LOCK;
          locked_d = 1'b1;
          step_d   = 3'd0;
          hold_d   = 16'd1;
        end
      end
      LOCK: begin
        // Stall check wins over the hold increment, so the counter never
        // exceeds MAX_HOLD and cannot wrap.
        if (led == pattern(step_q)) begin
          if (hold_q == HOLD_LIMIT) begin
            fault = 1'b1;
          end else begin
            hold_d = hold_q + 16'd1;
          end
        end else if (led == pattern(step_q + 3'd1)) begin
          step_d = step_q + 3'd1;
          hold_d = 16'd1;
          if (step_q == 3'd7) begin
            cycle_cnt_d = cycle_cnt_q + 8'd1;
          end
        end else begin
          fault = 1'b1;
        end
      end
      default: begin
        state_d = HUNT;
      end
    endcase

    // Error edges always land in HUNT; a re-lock is only possible next edge.
    if (fault) begin
      state_d   = HUNT;
      locked_d  = 1'b0;
      step_d    = 3'd0;
      hold_d    = '0;
      err_d     = 1'b1;
      err_cnt_d = (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rs) begin
    if (rs) begin
      state_q     <= HUNT;
      locked_q    <= 1'b0;
      step_q      <= '0;
      hold_q      <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      locked_q    <= locked_d;
      step_q      <= step_d;
      hold_q      <= hold_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign locked    = locked_q;
  assign step      = step_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;
  assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_led_seq_checker.sv
// tb_led_seq_checker
//   Drives two checkers (MAX_HOLD=1 and MAX_HOLD=4) from one LED bus. The
//   stimulus process advances an integer-level reference model per clock and
//   queues the expected outputs; the monitor pops one entry per clock edge
//   for each checker and compares.
module tb_led_seq_checker;

  logic       clk;
  logic       rs;
  logic [7:0] led;

  logic       lk1, er1, lk4, er4;
  logic [2:0] st1, st4;
  logic [7:0] ec1, cc1, ec4, cc4;

  led_seq_checker #(.MAX_HOLD(1)) dut1 (
    .clk(clk), .rs(rs), .led(led), .locked(lk1), .step(st1),
    .err(er1), .err_cnt(ec1), .cycle_cnt(cc1)
  );

  led_seq_checker #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .rs(rs), .led(led), .locked(lk4), .step(st4),
    .err(er4), .err_cnt(ec4), .cycle_cnt(cc4)
  );

  localparam logic [7:0] PAT [8] = '{8'h00, 8'h03, 8'h0F, 8'h3F,
                                     8'hFF, 8'hFC, 8'hF0, 8'hC0};

  typedef struct {
    bit lk;
    int stp;
    int hold;
    bit e;
    int ecnt;
    int ccnt;
  } mstate_t;

  mstate_t m1, m4;
  mstate_t q1[$];
  mstate_t q4[$];

  int n_cmp = 0;
  int n_bad = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  function automatic mstate_t reset_state();
    mstate_t z;
    z.lk = 0; z.stp = 0; z.hold = 0; z.e = 0; z.ecnt = 0; z.ccnt = 0;
    return z;
  endfunction

  // Next observable state after one clock with bus value v.
  function automatic mstate_t model_next(mstate_t s, logic [7:0] v, bit r, int maxh);
    mstate_t n;
    bit bad;
    n = s;
    n.e = 0;
    bad = 0;
    if (r) return reset_state();
    if (!s.lk) begin
      if (v == 8'h00) begin
        n.lk = 1; n.stp = 0; n.hold = 1;
      end
    end else if (v == PAT[s.stp]) begin
      if (s.hold >= maxh) bad = 1;
      else n.hold = s.hold + 1;
    end else if (v == PAT[(s.stp + 1) % 8]) begin
      if (s.stp == 7) n.ccnt = (s.ccnt + 1) % 256;
      n.stp = (s.stp + 1) % 8;
      n.hold = 1;
    end else begin
      bad = 1;
    end
    if (bad) begin
      n.lk = 0; n.stp = 0; n.hold = 0; n.e = 1;
      n.ecnt = (s.ecnt < 255) ? s.ecnt + 1 : 255;
    end
    return n;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [7:0] v, input bit r);
    @(negedge clk);
    led = v;
    rs  = r;
    m1 = model_next(m1, v, r, 1);
    m4 = model_next(m4, v, r, 4);
    q1.push_back(m1);
    q4.push_back(m4);
  endtask

  // Monitor: one expected entry per checker per rising edge.
  initial begin
    mstate_t e1, e4;
    forever begin
      @(posedge clk);
      #1;
      if (q1.size() > 0) begin
        e1 = q1.pop_front();
        chk("d1.locked", int'(lk1), int'(e1.lk));
        chk("d1.step", int'(st1), e1.stp);
        chk("d1.err", int'(er1), int'(e1.e));
        chk("d1.err_cnt", int'(ec1), e1.ecnt);
        chk("d1.cycle_cnt", int'(cc1), e1.ccnt);
      end
      if (q4.size() > 0) begin
        e4 = q4.pop_front();
        chk("d4.locked", int'(lk4), int'(e4.lk));
        chk("d4.step", int'(st4), e4.stp);
        chk("d4.err", int'(er4), int'(e4.e));
        chk("d4.err_cnt", int'(ec4), e4.ecnt);
        chk("d4.cycle_cnt", int'(cc4), e4.ccnt);
      end
    end
  end

  initial begin
    int sel;
    logic [7:0] v;
    m1 = reset_state();
    m4 = reset_state();
    rs  = 1'b1;
    led = 8'h00;

    // Reset, then release: first edge after release is a HUNT edge.
    drive(8'h00, 1);
    drive(8'h00, 1);

    // One clean fill/drain cycle ending back on 00.
    for (int i = 0; i <= 8; i++) drive(PAT[i % 8], 0);

    // Skip from step 2 to FF is a mismatch; 00 then re-locks.
    drive(8'h03, 0);
    drive(8'h0F, 0);
    drive(8'hFF, 0);
    drive(8'h00, 0);

    // Hold 03 for four clocks then advance; then hold it for five.
    for (int i = 0; i < 4; i++) drive(8'h03, 0);
    drive(8'h0F, 0);
    drive(8'h00, 0);
    drive(8'h00, 0);
    for (int i = 0; i < 5; i++) drive(8'h03, 0);

    // 256 forced mismatches drive err_cnt into saturation.
    drive(8'h55, 0);
    for (int i = 0; i < 256; i++) begin
      drive(8'h00, 0);
      drive(8'h55, 0);
    end

    // Non-zero value while hunting: nothing happens.
    for (int i = 0; i < 10; i++) drive(8'h5A, 0);

    // 256 clean cycles wrap cycle_cnt, then stop at step 5.
    drive(8'h00, 0);
    for (int c = 0; c < 256; c++)
      for (int i = 1; i <= 8; i++) drive(PAT[i % 8], 0);
    for (int i = 1; i <= 5; i++) drive(PAT[i], 0);

    // Asynchronous reset mid-cycle while locked at step 5.
    @(posedge clk);
    #3;
    rs = 1'b1;
    #1;
    chk("async.locked1", int'(lk1), 0);
    chk("async.step1", int'(st1), 0);
    chk("async.err1", int'(er1), 0);
    chk("async.err_cnt1", int'(ec1), 0);
    chk("async.cycle_cnt1", int'(cc1), 0);
    chk("async.locked4", int'(lk4), 0);
    chk("async.step4", int'(st4), 0);
    chk("async.err4", int'(er4), 0);
    chk("async.err_cnt4", int'(ec4), 0);
    chk("async.cycle_cnt4", int'(cc4), 0);
    m1 = reset_state();
    m4 = reset_state();
    drive(8'h00, 1);
    drive(8'h00, 0);
    drive(8'h03, 0);

    // Randomized traffic biased toward legal sequencing.
    for (int n = 0; n < 3000; n++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 55)      v = m4.lk ? PAT[(m4.stp + 1) % 8] : 8'h00;
      else if (sel < 75) v = PAT[m4.stp];
      else if (sel < 85) v = 8'h00;
      else               v = 8'($urandom_range(0, 255));
      drive(v, sel >= 98);
    end
    drive(8'h00, 0);

    @(posedge clk);
    #3;
    chk("q1_drain", q1.size(), 0);
    chk("q4_drain", q4.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
